// File: rtl/fpr_cdb_arbiter_if.sv
// Dispatch handshake and FPR common data bus shared by the floating-point units
// and fpr_cdb_arbiter.
interface fpr_cdb_arbiter_if #(
  parameter int N_UNIT    = 4,
  parameter int ROB_WIDTH = 4
);
  logic [N_UNIT-1:0]           req_valid;
  logic [N_UNIT-1:0]           req_ready;
  logic [N_UNIT*ROB_WIDTH-1:0] req_tag;
  logic [N_UNIT*32-1:0]        unit_result;
  logic                        cdb_valid;
  logic [ROB_WIDTH-1:0]        cdb_tag;
  logic [31:0]                 cdb_data;

  modport master (
    output req_valid, req_tag, unit_result,
    input  req_ready, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  req_valid, req_tag, unit_result,
    output req_ready, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/fpr_cdb_arbiter.sv
// Grants FP unit dispatch only into CDB cycles nobody has claimed, then drives the FPR CDB.
// Define FPR_CDB_OUTREG_EN to register the CDB outputs (every effective latency grows by one).
module fpr_cdb_arbiter #(
  parameter int                      N_UNIT    = 4,
  parameter int                      ROB_WIDTH = 4,
  parameter int                      LAT_W     = 3,
  parameter logic [N_UNIT*LAT_W-1:0] LATENCY   = {3'd1, 3'd4, 3'd2, 3'd2},
  parameter int                      LAT_MAX   = 4
) (
  input logic              clk,
  input logic              reset_n,
  fpr_cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (N_UNIT > 1) ? $clog2(N_UNIT) : 1;

  function automatic int lat_of(input int u);
    return int'(LATENCY[u*LAT_W +: LAT_W]);
  endfunction

  // occ[k] set means the CDB cycle k clocks ahead is already promised
  logic [LAT_MAX:1]       occ, occ_nxt;
  logic [ROB_WIDTH-1:0]   slot_tag [LAT_MAX:1];
  logic [ROB_WIDTH-1:0]   slot_tag_nxt [LAT_MAX:1];
  logic [PTR_W-1:0]       slot_src [LAT_MAX:1];
  logic [PTR_W-1:0]       slot_src_nxt [LAT_MAX:1];
  logic                   cur_vld, cur_vld_nxt;
  logic [ROB_WIDTH-1:0]   cur_tag, cur_tag_nxt;
  logic [PTR_W-1:0]       cur_src, cur_src_nxt;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_nxt;

  logic [N_UNIT-1:0]      grant;
  logic [LAT_MAX:1]       gnt_slot;
  logic [ROB_WIDTH-1:0]   gnt_tag [LAT_MAX:1];
  logic [PTR_W-1:0]       gnt_src [LAT_MAX:1];

  logic                   mux_valid;
  logic [ROB_WIDTH-1:0]   mux_tag;
  logic [31:0]            mux_data;

  // Walk units in round-robin order; the first eligible unit of each latency takes its slot
  always_comb begin
    int u;
    int l;
    u          = 0;
    l          = 1;
    grant      = '0;
    gnt_slot   = '0;
    rr_ptr_nxt = rr_ptr;
    for (int k = 1; k <= LAT_MAX; k++) begin
      gnt_tag[k] = '0;
      gnt_src[k] = '0;
    end
    for (int i = 0; i < N_UNIT; i++) begin
      u = int'(rr_ptr) + i;
      if (u >= N_UNIT) u = u - N_UNIT;
      l = lat_of(u);
      if (bus.req_valid[u] && !occ[l] && !gnt_slot[l]) begin
        grant[u]    = 1'b1;
        gnt_slot[l] = 1'b1;
        gnt_tag[l]  = bus.req_tag[u*ROB_WIDTH +: ROB_WIDTH];
        gnt_src[l]  = PTR_W'(u);
      end
    end
    for (int j = 0; j < N_UNIT; j++) begin
      if (grant[j]) rr_ptr_nxt = (j == N_UNIT-1) ? '0 : PTR_W'(j + 1);
    end
  end

  assign bus.req_ready = grant & {N_UNIT{reset_n}};

  always_comb begin
    occ_nxt = {1'b0, occ[LAT_MAX:2] | gnt_slot[LAT_MAX:2]};
    for (int k = 1; k < LAT_MAX; k++) begin
      slot_tag_nxt[k] = gnt_slot[k+1] ? gnt_tag[k+1] : slot_tag[k+1];
      slot_src_nxt[k] = gnt_slot[k+1] ? gnt_src[k+1] : slot_src[k+1];
    end
    slot_tag_nxt[LAT_MAX] = '0;
    slot_src_nxt[LAT_MAX] = '0;
    cur_vld_nxt = occ[1] | gnt_slot[1];
    cur_tag_nxt = gnt_slot[1] ? gnt_tag[1] : slot_tag[1];
    cur_src_nxt = gnt_slot[1] ? gnt_src[1] : slot_src[1];
  end

  // Reservation stage: control state is reset, tag/src payload simply follows it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ     <= '0;
      cur_vld <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      occ     <= occ_nxt;
      cur_vld <= cur_vld_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    slot_tag <= slot_tag_nxt;
    slot_src <= slot_src_nxt;
    cur_tag  <= cur_tag_nxt;
    cur_src  <= cur_src_nxt;
  end

  // Broadcast stage: the owning unit's result port is selected live
  always_comb begin
    mux_valid = cur_vld;
    mux_tag   = '0;
    mux_data  = '0;
    if (cur_vld) begin
      mux_tag  = cur_tag;
      mux_data = bus.unit_result[int'(cur_src)*32 +: 32];
    end
  end

`ifdef FPR_CDB_OUTREG_EN
  logic                 cdb_vld_p1;
  logic [ROB_WIDTH-1:0] cdb_tag_p1;
  logic [31:0]          cdb_data_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdb_vld_p1  <= 1'b0;
      cdb_tag_p1  <= '0;
      cdb_data_p1 <= '0;
    end else begin
      cdb_vld_p1  <= mux_valid;
      cdb_tag_p1  <= mux_tag;
      cdb_data_p1 <= mux_data;
    end
  end

  assign bus.cdb_valid = cdb_vld_p1;
  assign bus.cdb_tag   = cdb_tag_p1;
  assign bus.cdb_data  = cdb_data_p1;
`else
  assign bus.cdb_valid = mux_valid;
  assign bus.cdb_tag   = mux_tag;
  assign bus.cdb_data  = mux_data;
`endif
endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Scoreboard bench for fpr_cdb_arbiter: a calendar model predicts grants, and
// expected broadcasts are queued at dispatch and retired when they reach the CDB.
`timescale 1ns/100ps
module tb_fpr_cdb_arbiter;
  localparam int N_UNIT    = 4;
  localparam int ROB_WIDTH = 4;
  localparam int LAT_MAX   = 4;
`ifdef FPR_CDB_OUTREG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    int                   due;
    logic [ROB_WIDTH-1:0] tag;
    int                   src;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fpr_cdb_arbiter_if #(.N_UNIT(N_UNIT), .ROB_WIDTH(ROB_WIDTH)) bus ();

  fpr_cdb_arbiter #(.N_UNIT(N_UNIT), .ROB_WIDTH(ROB_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t                 sb[$];
  bit                   cal [0:1023];
  int                   n_chk  = 0;
  int                   n_pass = 0;
  int                   cyc    = 0;
  int                   mrr    = 0;
  int                   bcast  = 0;
  logic [N_UNIT-1:0]    want;
  logic [ROB_WIDTH-1:0] utag [N_UNIT];
  bit                   fix_mode = 1'b0;

  function automatic int lat(input int u);
    case (u)
      0: return 2;
      1: return 2;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] res_val(input int u, input int c);
    if (fix_mode && u == 0) return 32'h3F80_0000;
    return {4'hA, 4'(u), 8'(c), 16'(c*37 + u*1021)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // Per latency, the first requester in round-robin order wins if that CDB cycle is free
  function automatic logic [N_UNIT-1:0] model_grant();
    logic [N_UNIT-1:0] g;
    bit done;
    int u;
    g = '0;
    for (int l = 1; l <= LAT_MAX; l++) begin
      done = cal[cyc+l];
      for (int i = 0; i < N_UNIT; i++) begin
        u = (mrr + i) % N_UNIT;
        if (!done && want[u] && lat(u) == l) begin
          g[u] = 1'b1;
          done = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic drive();
    bus.req_valid = want;
    for (int u = 0; u < N_UNIT; u++) begin
      bus.req_tag[u*ROB_WIDTH +: ROB_WIDTH] = utag[u];
      bus.unit_result[u*32 +: 32]           = res_val(u, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) cal[i] = 1'b0;
    sb.delete();
    mrr = 0;
  endtask

  task automatic run_cycle();
    logic [N_UNIT-1:0] g;
    int   hit;
    exp_t e;
    drive();
    @(negedge clk);
    g = model_grant();
    check_eq("req_ready", 32'(bus.req_ready), 32'(g));
    hit = -1;
    foreach (sb[i]) if (sb[i].due == cyc) hit = i;
    if (bus.cdb_valid === 1'b1) bcast++;
    if (hit >= 0) begin
      check_eq("cdb_valid", 32'(bus.cdb_valid), 32'd1);
      check_eq("cdb_tag", 32'(bus.cdb_tag), 32'(sb[hit].tag));
      check_eq("cdb_data", bus.cdb_data, res_val(sb[hit].src, cyc - EXTRA));
      sb.delete(hit);
    end else begin
      check_eq("cdb_idle_valid", 32'(bus.cdb_valid), 32'd0);
      check_eq("cdb_idle_tag", 32'(bus.cdb_tag), 32'd0);
      check_eq("cdb_idle_data", bus.cdb_data, 32'd0);
    end
    @(posedge clk);
    for (int u = 0; u < N_UNIT; u++) begin
      if (g[u]) begin
        e.due = cyc + lat(u) + EXTRA;
        e.tag = utag[u];
        e.src = u;
        sb.push_back(e);
        cal[cyc+lat(u)] = 1'b1;
        utag[u] = utag[u] + 4'd1;
        mrr = (u + 1) % N_UNIT;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    want = '0;
    repeat (n) run_cycle();
  endtask

  task automatic reset_pulse();
    int pending;
    pending = 0;
    foreach (sb[i]) if (sb[i].due == cyc) pending = 1;
    #1;
    check_eq("pre_reset_valid", 32'(bus.cdb_valid), 32'(pending));
    want = '1;
    drive();
    #1 reset_n = 1'b0;
    #0.5;
    check_eq("rst_async_valid", 32'(bus.cdb_valid), 32'd0);
    check_eq("rst_async_tag", 32'(bus.cdb_tag), 32'd0);
    check_eq("rst_async_data", bus.cdb_data, 32'd0);
    check_eq("rst_async_ready", 32'(bus.req_ready), 32'd0);
    want = '0;
    drive();
    #0.5 reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    int b0;
    for (int u = 0; u < N_UNIT; u++) utag[u] = 4'(u * 4);
    model_clear();
    want = '1;
    drive();
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_valid", 32'(bus.cdb_valid), 32'd0);
    check_eq("rst_tag", 32'(bus.cdb_tag), 32'd0);
    check_eq("rst_data", bus.cdb_data, 32'd0);
    want = '0;
    drive();
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    // Single fadd dispatch, tag 5, result 1.0
    fix_mode = 1'b1;
    utag[0]  = 4'd5;
    want     = 4'b0001;
    run_cycle();
    idle(5);
    fix_mode = 1'b0;

    // Park rr_ptr at 0 via a misc grant, then fadd/fmul contend for the L=2 slot
    want = 4'b1000;
    run_cycle();
    idle(2);
    utag[0] = 4'd1;
    utag[1] = 4'd8;
    want = 4'b0011;
    repeat (6) run_cycle();
    idle(5);

    // finv claims t+4; fadd at t+2 must wait one cycle
    want = 4'b0100;
    run_cycle();
    idle(1);
    want = 4'b0001;
    repeat (2) run_cycle();
    idle(6);

    // misc and fadd in the same cycle land on consecutive CDB cycles
    want = 4'b1001;
    run_cycle();
    idle(4);

    // Everyone requests for 50 cycles; the bus should be saturated once filled
    want = 4'b1111;
    repeat (6) run_cycle();
    b0 = bcast;
    repeat (44) run_cycle();
    check_eq("saturated_bcasts", 32'(bcast - b0), 32'd44);
    idle(LAT_MAX + 3);
    check_eq("drain_empty", 32'(sb.size()), 32'd0);

    // Reset with two reservations in flight, then first grant right after
    want = 4'b0101;
    run_cycle();
    idle(1);
    reset_pulse();
    idle(6);
    want = 4'b0010;
    run_cycle();
    idle(LAT_MAX + 2);
    check_eq("final_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
